// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_pkg
// Description : Shared types for the round-robin stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_rr_pkg;

    // Arbitration state. LOCKED is only ever entered when packet locking is enabled.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } mux_state_t;

endpackage : stream_mux_rr_pkg
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting one past the previous grant, wrapping
//               through a double-width copy of the requests.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_grant,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [2*N_CH-1:0] w_req_dbl;
    logic [SEL_W:0]    w_pos;
    logic              w_found;

    // First requester after last_grant wins; the doubled vector removes the wrap special case.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = '0;
        w_req_dbl = {req, req};
        for (int k = 1; k <= N_CH; k++) begin
            w_pos = {1'b0, last_grant} + (SEL_W+1)'(k);
            if (!w_found && w_req_dbl[w_pos]) begin
                w_found = 1'b1;
                if (w_pos >= (SEL_W+1)'(N_CH)) begin
                    grant_idx = SEL_W'(w_pos - (SEL_W+1)'(N_CH));
                end else begin
                    grant_idx = SEL_W'(w_pos);
                end
            end
        end
        if (w_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel valid/ready stream multiplexer with round-robin
//               arbitration, optional packet locking and a single registered
//               output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int N_CH         = 4,
    parameter  int WIDTH        = 8,
    parameter  int LOCK_ON_LAST = 1,
    localparam int SEL_W        = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready,
    output logic                  busy
);

    mux_state_t       r_state;
    mux_state_t       w_state_nxt;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] r_last_grant;

    logic [N_CH-1:0]  w_arb_grant;
    logic [SEL_W-1:0] w_arb_idx;
    logic [N_CH-1:0]  w_grant;
    logic [SEL_W-1:0] w_idx;
    logic             w_load_en;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req        (in_valid),
        .last_grant (r_last_grant),
        .grant      (w_arb_grant),
        .grant_idx  (w_arb_idx)
    );

    // Output stage can take a new beat when empty or being drained this cycle.
    assign w_load_en = !out_valid || out_ready;
    assign in_ready  = w_grant & {N_CH{w_load_en}};
    assign w_accept  = |(in_valid & in_ready);
    assign busy      = (r_state == ST_LOCKED);

    // While locked the grant is pinned to the owning channel, valid or not, so nothing interleaves.
    always_comb begin
        w_grant = w_arb_grant;
        w_idx   = w_arb_idx;
        if (r_state == ST_LOCKED) begin
            w_grant           = '0;
            w_grant[r_lock_ch] = 1'b1;
            w_idx             = r_lock_ch;
        end
    end

    // Pick the granted channel's payload.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == w_idx) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
                w_sel_last = in_last[i];
            end
        end
    end

    // Next-state: lock on a non-final beat, unlock when the owner's final beat is taken.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE) begin
            if ((LOCK_ON_LAST != 0) && w_accept && !w_sel_last) begin
                w_state_nxt = ST_LOCKED;
            end
        end else begin
            if (w_accept && w_sel_last) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State register and lock owner capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_accept) begin
                r_lock_ch <= w_idx;
            end
        end
    end

    // Output register; last_grant starts at the top channel so ch0 wins first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_sel      <= '0;
            r_last_grant <= SEL_W'(N_CH - 1);
        end else if (w_load_en) begin
            out_valid <= w_accept;
            if (w_accept) begin
                out_data     <= w_sel_data;
                out_last     <= w_sel_last;
                out_sel      <= w_idx;
                r_last_grant <= w_idx;
            end
        end
    end

endmodule : stream_mux_rr
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Self-checking bench for stream_mux_rr with a reference model
//               and a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic        busy;

    logic [3:0]  in_ready_nl;
    logic        out_valid_nl;
    logic [7:0]  out_data_nl;
    logic        out_last_nl;
    logic [1:0]  out_sel_nl;
    logic        busy_nl;

    stream_mux_rr #(.N_CH(4), .WIDTH(8), .LOCK_ON_LAST(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_sel(out_sel), .out_ready(out_ready), .busy(busy)
    );

    stream_mux_rr #(.N_CH(4), .WIDTH(8), .LOCK_ON_LAST(0)) dut_nl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_nl), .out_valid(out_valid_nl), .out_data(out_data_nl), .out_last(out_last_nl),
        .out_sel(out_sel_nl), .out_ready(out_ready), .busy(busy_nl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    m_last_grant = 3;
    bit    m_locked     = 1'b0;
    int    m_lock_ch    = 0;

    function automatic int model_grant();
        if (m_locked) return m_lock_ch;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last_grant + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last_grant = 3;
            m_locked     = 1'b0;
            m_lock_ch    = 0;
            q.delete();
        end else begin
            int g;
            bit load;
            g    = model_grant();
            load = (q.size() == 0) || out_ready;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (load && g >= 0 && in_valid[g]) begin
                q.push_back('{g, in_data[g*8 +: 8], in_last[g]});
                m_last_grant = g;
                if (!m_locked && !in_last[g]) begin
                    m_locked  = 1'b1;
                    m_lock_ch = g;
                end else if (m_locked && in_last[g]) begin
                    m_locked = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            int         g;
            logic [3:0] er;
            g  = model_grant();
            er = 4'b0;
            if (g >= 0 && ((q.size() == 0) || out_ready)) er[g] = 1'b1;
            if (out_valid && out_ready) xfers++;
            check("in_ready", in_ready, er);
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("sb_sel", out_sel, q[0].sel);
                check("sb_data", out_data, q[0].data);
                check("sb_last", out_last, q[0].last);
            end
            check("busy", busy, m_locked);
            check("busy_nolock", busy_nl, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};
        int base;

        // 1: reset with random inputs
        rst       = 1'b1;
        in_valid  = 4'($urandom);
        in_data   = $urandom;
        in_last   = 4'($urandom);
        out_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_busy", busy, 0);
        step();
        rst       = 1'b0;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;
        mon_en    = 1'b1;
        @(negedge clk);
        check("first_grant", in_ready, 4'b0001);
        check("pre_latency_valid", out_valid, 0);

        // 2: round-robin rotation, one beat per cycle
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rr_valid", out_valid, 1);
            check("rr_sel", out_sel, seq[i]);
            check("rr_data", out_data, 8'hA0 + seq[i]);
        end
        step();
        in_valid = 4'h0;
        step();
        step();

        // 3: backpressure hold
        in_valid  = 4'b0010;
        in_data   = {8'h33, 8'h22, 8'h5A, 8'h00};
        out_ready = 1'b0;
        step();
        in_valid = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data", out_data, 8'h5A);
            check("bp_sel", out_sel, 1);
            check("bp_ready", in_ready, 4'b0000);
        end
        step();
        in_valid  = 4'h0;
        out_ready = 1'b1;
        base      = xfers;
        step();
        step();
        step();
        check("bp_once", xfers - base, 1);

        // 4: packet lock on ch2 while ch0/ch1 compete
        in_valid = 4'b0111;
        in_last  = 4'b1011;
        in_data  = {8'h00, 8'hC0, 8'h11, 8'h10};
        step();
        in_data[23:16] = 8'hC1;
        @(negedge clk);
        check("lk_busy1", busy, 1);
        check("lk_sel1", out_sel, 2);
        check("lk_data1", out_data, 8'hC0);
        step();
        in_data[23:16] = 8'hC2;
        in_last[2]     = 1'b1;
        @(negedge clk);
        check("lk_busy2", busy, 1);
        check("lk_data2", out_data, 8'hC1);
        step();
        in_valid[2] = 1'b0;
        @(negedge clk);
        check("lk_busy3", busy, 0);
        check("lk_data3", out_data, 8'hC2);
        check("lk_next_grant", in_ready, 4'b0001);
        step();
        in_valid = 4'h0;
        step();

        // 5: lock stall, owner idles while ch3 waits
        in_valid = 4'b0010;
        in_last  = 4'b1000;
        in_data  = {8'hE3, 8'h00, 8'hD0, 8'h00};
        step();
        in_valid = 4'b1000;
        @(negedge clk);
        check("st_ready1", in_ready, 4'b0010);
        step();
        @(negedge clk);
        check("st_ready2", in_ready, 4'b0010);
        step();
        in_valid       = 4'b1010;
        in_last        = 4'b1010;
        in_data[15:8]  = 8'hD1;
        step();
        @(negedge clk);
        check("st_sel_owner", out_sel, 1);
        check("st_data_owner", out_data, 8'hD1);
        check("st_ready_ch3", in_ready, 4'b1000);
        step();
        in_valid = 4'h0;
        @(negedge clk);
        check("st_sel_ch3", out_sel, 3);
        check("st_data_ch3", out_data, 8'hE3);
        step();

        // 6: reset in the middle of a locked packet
        in_valid = 4'b0001;
        in_last  = 4'b0000;
        in_data  = {8'h00, 8'h00, 8'h00, 8'hF0};
        step();
        @(negedge clk);
        check("mr_busy_pre", busy, 1);
        step();
        rst = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_busy_nolock", busy_nl, 0);
        check("mr_out_valid_nolock", out_valid_nl, 0);
        in_valid = 4'hF;
        in_last  = 4'hF;
        in_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mr_first_grant", in_ready, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        check("mr_sel", out_sel, 0);
        check("mr_data", out_data, 8'hB0);
        step();
        in_valid = 4'h0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stream_mux_rr
`default_nettype wire
